// File: rtl/core_pkg.sv
// Shared constants and types for the dual up/down counter block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    // Default counter width and reset values used by core.
    localparam int CORE_WIDTH   = 4;
    localparam int CORE_UP_INIT = 0;

    // Counter value at the default width.
    typedef logic [CORE_WIDTH-1:0] cnt_t;

    // Count direction selector for updown_counter.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/core_updown.sv
// Single registered wrap-around counter, direction fixed at elaboration.
// Latency: value changes on the same rising edge that sees step_en=1.
// Backpressure: none; free-running whenever step_en is high.
module updown_counter
    import core_pkg::*;
#(
    parameter int               WIDTH = CORE_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter dir_e             DIR   = DIR_UP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    output logic [WIDTH-1:0] cnt
);

    // Reset wins over stepping; arithmetic wraps naturally at WIDTH bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= INIT;
        end else if (step_en) begin
            if (DIR == DIR_UP) begin
                cnt <= cnt + WIDTH'(1);
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/core.sv
// Paired up/down counters sharing one clock-divider prescaler.
// Latency: first step on the DIV-th rising edge after reset release.
// Backpressure: none; counters run freely while reset is high.
module core
    import core_pkg::*;
#(
    parameter int               WIDTH     = CORE_WIDTH,
    parameter logic [WIDTH-1:0] UP_INIT   = WIDTH'(CORE_UP_INIT),
    parameter logic [WIDTH-1:0] DOWN_INIT = {WIDTH{1'b1}},
    parameter int               DIV       = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] up_cnt,
    output logic [WIDTH-1:0] down_cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic step_en;

    generate
        if (DIV > 1) begin : g_presc
            logic [PW-1:0] presc;

            // Prescaler cycles 0..DIV-1; terminal value releases one step.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    presc <= '0;
                end else if (presc == PW'(DIV - 1)) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            assign step_en = (presc == PW'(DIV - 1));
        end else begin : g_no_presc
            // Without division every released edge is a step.
            assign step_en = 1'b1;
        end
    endgenerate

    updown_counter #(
        .WIDTH (WIDTH),
        .INIT  (UP_INIT),
        .DIR   (DIR_UP)
    ) u_up (
        .clk     (clk),
        .reset   (reset),
        .step_en (step_en),
        .cnt     (up_cnt)
    );

    updown_counter #(
        .WIDTH (WIDTH),
        .INIT  (DOWN_INIT),
        .DIR   (DIR_DOWN)
    ) u_down (
        .clk     (clk),
        .reset   (reset),
        .step_en (step_en),
        .cnt     (down_cnt)
    );

endmodule

// File: tb/tb_core.sv
// Bench for core: default, divided and non-default-init instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_core;
    import core_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] up_a, dn_a, up_b, dn_b;
    logic [2:0] up_c, dn_c;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;   // released edges since last reset edge

    core u_a (
        .clk      (clk),
        .reset    (reset),
        .up_cnt   (up_a),
        .down_cnt (dn_a)
    );

    core #(.DIV(3)) u_b (
        .clk      (clk),
        .reset    (reset),
        .up_cnt   (up_b),
        .down_cnt (dn_b)
    );

    core #(.WIDTH(3), .UP_INIT(3'd5), .DOWN_INIT(3'd2)) u_c (
        .clk      (clk),
        .reset    (reset),
        .up_cnt   (up_c),
        .down_cnt (dn_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: counters equal init +/- (steps taken), steps = edges/DIV, mod 2**W.
    task automatic check_model();
        logic [3:0] ua, da, ia, ub, db;
        logic [2:0] uc, dc;
        int n;
        ua = 4'(edges);
        da = 4'(15 - edges);
        ia = ~ua;
        n  = edges / 3;
        ub = 4'(n);
        db = 4'(15 - n);
        uc = 3'(5 + edges);
        dc = 3'(2 - edges);
        chk("a_up", up_a, ua);
        chk("a_dn", dn_a, da);
        chk("a_inv", dn_a, ia);
        chk("b_up", up_b, ub);
        chk("b_dn", dn_b, db);
        chk("c_up", {1'b0, up_c}, {1'b0, uc});
        chk("c_dn", {1'b0, dn_c}, {1'b0, dc});
    endtask

    task automatic tick(input logic r);
        reset = r;
        @(posedge clk);
        if (!r) edges = 0;
        else    edges++;
        #1;
        check_model();
    endtask

    initial begin
        logic [3:0] seq_b [6];
        seq_b = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};

        // Reset hold for five edges.
        repeat (5) begin
            tick(1'b0);
            chk("hold_up", up_a, 4'h0);
            chk("hold_dn", dn_a, 4'hF);
        end

        // Release: 1/E, 2/D, 3/C; divided instance first steps on edge 3.
        tick(1'b1);
        chk("rel1_up", up_a, 4'h1);
        chk("rel1_dn", dn_a, 4'hE);
        chk("rel1_b", up_b, 4'h0);
        tick(1'b1);
        chk("rel2_up", up_a, 4'h2);
        chk("rel2_dn", dn_a, 4'hD);
        chk("rel2_b", up_b, 4'h0);
        tick(1'b1);
        chk("rel3_up", up_a, 4'h3);
        chk("rel3_dn", dn_a, 4'hC);
        chk("rel3_b", up_b, 4'h1);

        // Wrap over 50 edges, with the divided sequence checked on the way.
        tick(1'b0);
        for (int i = 1; i <= 50; i++) begin
            tick(1'b1);
            if (i <= 6) chk("div_seq", up_b, seq_b[i-1]);
            if (i == 15) begin
                chk("wrap15_up", up_a, 4'hF);
                chk("wrap15_dn", dn_a, 4'h0);
            end
            if (i == 16) begin
                chk("wrap16_up", up_a, 4'h0);
                chk("wrap16_dn", dn_a, 4'hF);
            end
            if (i == 50) begin
                chk("e50_up", up_a, 4'h2);
                chk("e50_dn", dn_a, 4'hD);
            end
        end

        // Mid-count reset at up=7.
        tick(1'b0);
        repeat (7) tick(1'b1);
        chk("mid_pre", up_a, 4'h7);
        tick(1'b0);
        chk("mid_up", up_a, 4'h0);
        chk("mid_dn", dn_a, 4'hF);
        chk("mid_b", up_b, 4'h0);
        tick(1'b1);
        chk("mid_rel_up", up_a, 4'h1);
        chk("mid_rel_dn", dn_a, 4'hE);

        // Random reset pulses against the reference model.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(9, 0) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of both counters, legal range 1..32.
REQ-002 SHALL have parameter UP_INIT, default 0: reset value of up_cnt.
REQ-003 SHALL have parameter DOWN_INIT, default 2**WIDTH-1 (all ones): reset value of down_cnt.
REQ-004 SHALL have parameter DIV, default 1: clocks per count step, legal range 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-007 SHALL have port up_cnt, output, WIDTH bits: incrementing counter value, registered.
REQ-008 SHALL have port down_cnt, output, WIDTH bits: decrementing counter value, registered.

Function
REQ-009 SHALL hold up_cnt=UP_INIT and down_cnt=DOWN_INIT on every rising edge where reset=0.
REQ-010 SHALL, with DIV=1, add 1 to up_cnt and subtract 1 from down_cnt on every rising edge where reset=1.
REQ-011 SHALL update up_cnt on the first rising edge where reset=1 (UP_INIT -> UP_INIT+1), with zero extra latency.
REQ-012 SHALL wrap up_cnt modulo 2**WIDTH: all ones -> 0, no saturation, no flag.
REQ-013 SHALL wrap down_cnt modulo 2**WIDTH: 0 -> all ones, no saturation, no flag.
REQ-014 SHALL, with defaults, keep down_cnt == ~up_cnt on every cycle. For other parameter values the two counters are independent.
REQ-015 SHALL, with DIV>1, use an internal prescaler that counts 0..DIV-1. Both counters step together only on the edge where the prescaler is at DIV-1.
REQ-016 SHALL clear the prescaler to 0 on reset. The first step after reset release therefore occurs on the DIV-th active edge.
REQ-017 SHALL, on reset asserted mid-count, return both counters and the prescaler to their reset values on that same edge, regardless of their current values.
REQ-018 SHALL drive outputs directly from flops, with no combinational path from reset to the outputs.

Reset
REQ-019 SHALL sample reset only on the rising edge of clk, with no asynchronous behaviour.
REQ-020 SHALL give every flop (both counters, prescaler) a defined reset value.
REQ-021 SHALL produce no X on the outputs after the first reset edge.

Structure
REQ-022 SHALL take the WIDTH default and the reset-value constants from a shared package, core_pkg, which also defines the counter type logic [WIDTH-1:0].
REQ-023 SHALL implement each counter as an instance of one sub-module, updown_counter. Its parameters are WIDTH, INIT and DIR (up/down); its inputs are clk, reset and step enable; its output is the counter value.
REQ-024 SHALL instantiate updown_counter twice inside core, driven by one shared prescaler.

Verification
REQ-025 SHALL cover reset hold: reset=0 for 5 edges -> up_cnt=0x0 and down_cnt=0xF on every edge.
REQ-026 SHALL cover release: reset=1; after edges 1, 2 and 3 -> up/down = 1/E, 2/D, 3/C.
REQ-027 SHALL cover wrap: 50 edges after release -> up_cnt passes F->0 at edge 16 and down_cnt passes 0->F at edge 16. At edge 50, up=0x2 and down=0xD.
REQ-028 SHALL cover mid-count reset: reset=0 for one edge while up=0x7 -> next sample is up=0x0, down=0xF; counting resumes 1/E after release.
REQ-029 SHALL cover the invariant: down_cnt == ~up_cnt checked on every edge with defaults.
REQ-030 SHALL cover prescaler: DIV=3 -> counters change only every 3rd edge after release (0,0,1,1,1,2...). First change is at edge 3.
